// File: rtl/hazard_ctrl.sv
// Hazard and flush controller for a 5-stage pipeline: a 2-slot destination scoreboard
// (EX, MEM) checked against the decode operands, with branch gating and perf counters.
module hazard_ctrl #(
  parameter int   CNT_W       = 16,
  parameter logic FWD_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_mode_we,
  input  logic             fwd_mode_in,
  input  logic             id_valid,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic [4:0]       id_dest,
  input  logic             branch_taken_in,
  output logic             hazard_detected,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             branch_taken_out,
  output logic             fwd_mode,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Register $0 is hard-wired zero, so a slot writing it never matches.
  function automatic logic slot_match(input logic valid, input logic wb_en,
                                      input logic [4:0] dest, input logic [4:0] src1,
                                      input logic [4:0] src2, input logic two_src);
    return valid && wb_en && (dest != 5'd0) &&
           ((dest == src1) || (two_src && (dest == src2)));
  endfunction

  logic       ex_valid_q, ex_wb_q, ex_mr_q;
  logic [4:0] ex_dest_q;
  logic       ex_valid_d, ex_wb_d, ex_mr_d;
  logic [4:0] ex_dest_d;
  logic       mem_valid_q, mem_wb_q, mem_mr_q;
  logic [4:0] mem_dest_q;
  logic       fwd_q, fwd_d;
  state_t     state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  logic match_ex_s, match_mem_s, hazard_s, branch_s;

  // Hazard decision, branch gating and next-state for every register.
  always_comb begin
    match_ex_s  = 1'b0;
    match_mem_s = 1'b0;
    hazard_s    = 1'b0;
    branch_s    = 1'b0;
    ex_valid_d  = 1'b0;
    ex_wb_d     = 1'b0;
    ex_mr_d     = 1'b0;
    ex_dest_d   = 5'd0;
    fwd_d       = fwd_q;
    state_d     = ST_RUN;
    stall_d     = stall_q;
    flush_d     = flush_q;

    if (id_valid) begin
      match_ex_s  = slot_match(ex_valid_q, ex_wb_q, ex_dest_q, id_src1, id_src2, id_two_src);
      match_mem_s = slot_match(mem_valid_q, mem_wb_q, mem_dest_q, id_src1, id_src2, id_two_src);
    end else begin
      match_ex_s  = 1'b0;
      match_mem_s = 1'b0;
    end

    // With forwarding only a load still in EX is too late to bypass.
    if (fwd_q) begin
      hazard_s = match_ex_s && ex_mr_q;
    end else begin
      hazard_s = match_ex_s || match_mem_s;
    end

    branch_s = branch_taken_in && !hazard_s;

    if (id_valid && !hazard_s) begin
      ex_valid_d = 1'b1;
      ex_wb_d    = id_wb_en;
      ex_mr_d    = id_mem_read;
      ex_dest_d  = id_dest;
    end else begin
      ex_valid_d = 1'b0;
      ex_wb_d    = 1'b0;
      ex_mr_d    = 1'b0;
      ex_dest_d  = 5'd0;
    end

    if (fwd_mode_we) begin
      fwd_d = fwd_mode_in;
    end else begin
      fwd_d = fwd_q;
    end

    case ({hazard_s, branch_s})
      2'b10, 2'b11: state_d = ST_STALL;
      2'b01:        state_d = ST_FLUSH;
      2'b00:        state_d = ST_RUN;
      default:      state_d = ST_RUN;
    endcase

    if (hazard_s && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end

    if (branch_s && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_ONE;
    end else begin
      flush_d = flush_q;
    end
  end

  // State, scoreboard, mode and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_wb_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      ex_dest_q   <= 5'd0;
      mem_valid_q <= 1'b0;
      mem_wb_q    <= 1'b0;
      mem_mr_q    <= 1'b0;
      mem_dest_q  <= 5'd0;
      fwd_q       <= FWD_DEFAULT;
      state_q     <= ST_RUN;
      stall_q     <= {CNT_W{1'b0}};
      flush_q     <= {CNT_W{1'b0}};
    end else begin
      mem_valid_q <= ex_valid_q;
      mem_wb_q    <= ex_wb_q;
      mem_mr_q    <= ex_mr_q;
      mem_dest_q  <= ex_dest_q;
      ex_valid_q  <= ex_valid_d;
      ex_wb_q     <= ex_wb_d;
      ex_mr_q     <= ex_mr_d;
      ex_dest_q   <= ex_dest_d;
      fwd_q       <= fwd_d;
      state_q     <= state_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
    end
  end

  assign hazard_detected  = hazard_s;
  assign pc_freeze        = hazard_s;
  assign ifid_freeze      = hazard_s;
  assign branch_taken_out = branch_s;
  assign ifid_flush       = branch_s;
  assign fwd_mode         = fwd_q;
  assign state            = state_q;
  assign stall_count      = stall_q;
  assign flush_count      = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: an issue-history model checks every cycle,
// literal expectations pin the model at the interesting points.
module tb_hazard_ctrl;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk, rst;
  logic fwd_mode_we, fwd_mode_in, id_valid, id_two_src, id_wb_en, id_mem_read, branch_taken_in;
  logic [4:0] id_src1, id_src2, id_dest;
  logic hazard_detected, pc_freeze, ifid_freeze, ifid_flush, branch_taken_out, fwd_mode;
  logic [1:0] state;
  logic [CW-1:0] stall_count, flush_count;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.CNT_W(CW), .FWD_DEFAULT(1'b1)) dut (
    .clk(clk), .rst(rst), .fwd_mode_we(fwd_mode_we), .fwd_mode_in(fwd_mode_in),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
    .branch_taken_in(branch_taken_in), .hazard_detected(hazard_detected),
    .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush),
    .branch_taken_out(branch_taken_out), .fwd_mode(fwd_mode), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every instruction that left ID, stamped with the edge it entered EX.
  typedef struct {
    int         t;
    logic       wb;
    logic       mr;
    logic [4:0] dest;
  } ent_t;
  ent_t issued[$];
  int   now_m = 0;
  int   st_m = 0, stall_m = 0, flush_m = 0;
  logic fwd_m = 1'b1;

  always @(negedge clk) begin
    logic eh, eb;
    int   age;
    eh = 1'b0;
    eb = 1'b0;
    if (rst) begin
      issued.delete();
      now_m = 0; st_m = 0; stall_m = 0; flush_m = 0; fwd_m = 1'b1;
    end else begin
      foreach (issued[k]) begin
        age = now_m - issued[k].t;
        if (id_valid && issued[k].wb && issued[k].dest != 5'd0 &&
            (issued[k].dest == id_src1 || (id_two_src && issued[k].dest == id_src2)) &&
            ((fwd_m && age == 0 && issued[k].mr) || (!fwd_m && age <= 1)))
          eh = 1'b1;
      end
      eb = branch_taken_in && !eh;
    end
    chk("m_hazard", hazard_detected, eh);
    chk("m_pc_freeze", pc_freeze, eh);
    chk("m_ifid_freeze", ifid_freeze, eh);
    chk("m_branch_out", branch_taken_out, eb);
    chk("m_ifid_flush", ifid_flush, eb);
    chk("m_fwd_mode", fwd_mode, fwd_m);
    chk("m_state", state, st_m);
    chk("m_stall_count", stall_count, stall_m);
    chk("m_flush_count", flush_count, flush_m);
    if (!rst) begin
      now_m++;
      if (id_valid && !eh) issued.push_back('{now_m, id_wb_en, id_mem_read, id_dest});
      while (issued.size() > 0 && now_m - issued[0].t > 1) void'(issued.pop_front());
      st_m = eh ? 1 : (eb ? 2 : 0);
      if (eh && stall_m < CMAX) stall_m++;
      if (eb && flush_m < CMAX) flush_m++;
      if (fwd_mode_we) fwd_m = fwd_mode_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                     input logic two, input logic wb, input logic mr,
                     input logic [4:0] d, input logic br);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_wb_en = wb; id_mem_read = mr; id_dest = d; branch_taken_in = br;
  endtask

  task automatic nop();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; fwd_mode_we = 1'b0; fwd_mode_in = 1'b0;
    nop();
    #1 rst = 1'b1;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_fwd", fwd_mode, 1);
    rst = 1'b0;

    // Load-use with forwarding: one stall cycle.
    drv(1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0); #2;
    chk("lu_before", hazard_detected, 0);
    tick();
    drv(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0); #2;
    chk("lu_hazard", hazard_detected, 1);
    tick(); #1;
    chk("lu_released", hazard_detected, 0);
    chk("lu_state", state, 1);
    chk("lu_stall_count", stall_count, 1);
    tick();

    // Producer of r0, then single-source with src2 matching a live load.
    drv(1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0); tick();
    drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0); #2;
    chk("r0_no_stall", hazard_detected, 0);
    tick();
    drv(1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0); tick();
    drv(1'b1, 5'd1, 5'd9, 1'b0, 1'b1, 1'b0, 5'd6, 1'b0); #2;
    chk("one_src_no_stall", hazard_detected, 0);
    tick();

    // Switch to no-forwarding.
    nop(); fwd_mode_we = 1'b1; fwd_mode_in = 1'b0; tick();
    fwd_mode_we = 1'b0; #1;
    chk("fwd_off", fwd_mode, 0);

    // add r3,r1,r2 ; sub r4,r3,r3 -> two stalls.
    drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0); tick();
    drv(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0); #2;
    chk("nf_stall1", hazard_detected, 1);
    tick(); #1;
    chk("nf_stall2", hazard_detected, 1);
    chk("nf_count2", stall_count, 2);
    tick(); #1;
    chk("nf_done", hazard_detected, 0);
    chk("nf_count3", stall_count, 3);
    tick(); nop(); tick();

    // One independent instruction in between -> one stall.
    drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0); tick();
    drv(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0); tick();
    drv(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0); #2;
    chk("gap_stall", hazard_detected, 1);
    tick(); #1;
    chk("gap_done", hazard_detected, 0);
    chk("gap_count", stall_count, 4);
    tick(); nop(); tick();

    // Taken branch, no hazard.
    drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1); #2;
    chk("br_out", branch_taken_out, 1);
    chk("br_flush", ifid_flush, 1);
    tick(); nop(); #1;
    chk("br_state", state, 2);
    chk("br_count", flush_count, 1);
    tick();

    // Taken branch blocked by a hazard until the producer retires.
    drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0); tick();
    drv(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1); #2;
    chk("brh_gated1", branch_taken_out, 0);
    tick(); #1;
    chk("brh_gated2", branch_taken_out, 0);
    tick(); #1;
    chk("brh_released", branch_taken_out, 1);
    tick(); nop(); #1;
    chk("brh_flush_count", flush_count, 2);
    chk("brh_stall_count", stall_count, 6);
    tick();

    // Reset asserted mid-stall.
    drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0); tick();
    drv(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0); tick(); #1;
    chk("pre_rst_hazard", hazard_detected, 1);
    rst = 1'b1; #1;
    chk("rst_hazard", hazard_detected, 0);
    chk("rst_pc_freeze", pc_freeze, 0);
    chk("rst_state_mid", state, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_flush_count", flush_count, 0);
    chk("rst_fwd_default", fwd_mode, 1);
    tick();
    rst = 1'b0; #1;
    chk("redecode_no_hazard", hazard_detected, 0);
    tick();

    // Saturation: 20 load-use stalls on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0); tick();
      drv(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0); tick(); tick();
    end
    nop(); #1;
    chk("sat_stall_count", stall_count, 15);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
